// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC select encoding and default fetch-path constants.
package pc_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_INC   = 4;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS_SWAP,
        SEL_RAS_POP,
        SEL_SEQ,
        SEL_CALL,
        SEL_JUMP
    } next_pc_sel_e;

endpackage

// File: rtl/pc_unit_return_stack.sv
// pc_unit_return_stack: circular return-address LIFO with push, pop and top swap.
module pc_unit_return_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             swap_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_inc, ptr_dec;
    logic [CW-1:0]    cnt_q;

    assign ptr_inc = ptr_q + PW'(1);
    assign ptr_dec = ptr_q - PW'(1);
    assign top_o   = mem_q[ptr_q];
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);

    // A push when full wraps onto the oldest entry; count saturates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            ptr_q <= ptr_inc;
            cnt_q <= full_o ? cnt_q : cnt_q + CW'(1);
        end else if (pop_i) begin
            ptr_q <= ptr_dec;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i)
            mem_q[ptr_inc] <= data_i;
        else if (!rst_i && swap_i)
            mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, PC+INC adder and prioritised next-PC mux with return-address stack.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               INC          = DEFAULT_INC,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_target_i,
    input  logic             jump_i,
    input  logic             call_i,
    input  logic [WIDTH-1:0] jump_target_i,
    input  logic             return_i,
    output logic [WIDTH-1:0] pc_result_o,
    output logic [WIDTH-1:0] pc_add_result_o,
    output logic             ras_empty_o,
    output logic             ras_full_o,
    output logic             ras_underflow_o
);

    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic             uf_q, uf_d;
    next_pc_sel_e     sel;

    assign pc_result_o     = pc_q;
    assign pc_add_result_o = pc_q + WIDTH'(INC);
    assign ras_underflow_o = uf_q;

    always_comb
        sel = reset_i                     ? SEL_RESET    :
              redirect_i                  ? SEL_REDIRECT :
              stall_i                     ? SEL_HOLD     :
              (return_i && call_i)        ? SEL_RAS_SWAP :
              (return_i && !ras_empty_o)  ? SEL_RAS_POP  :
              return_i                    ? SEL_SEQ      :
              call_i                      ? SEL_CALL     :
              jump_i                      ? SEL_JUMP     : SEL_SEQ;

    always_comb begin
        pc_d = pc_q;
        uf_d = uf_q;
        unique case (sel)
            SEL_RESET:    begin pc_d = RESET_VECTOR; uf_d = 1'b0; end
            SEL_REDIRECT: pc_d = redirect_target_i;
            SEL_HOLD:     pc_d = pc_q;
            SEL_RAS_SWAP: pc_d = ras_top;
            SEL_RAS_POP:  pc_d = ras_top;
            SEL_CALL:     pc_d = jump_target_i;
            SEL_JUMP:     pc_d = jump_target_i;
            // Only an empty-stack Return reaches SEQ with return_i high.
            SEL_SEQ:      begin pc_d = pc_add_result_o; uf_d = uf_q | return_i; end
            default:      pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_VECTOR;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end

    pc_unit_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (sel == SEL_CALL),
        .pop_i   (sel == SEL_RAS_POP),
        .swap_i  (sel == SEL_RAS_SWAP),
        .data_i  (pc_add_result_o),
        .top_o   (ras_top),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with a queued scoreboard checked by a separate monitor.
module tb_pc_unit;

    typedef struct {
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        uf;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, jump, call, ret;
    logic [31:0] redirect_target, jump_target;
    logic [31:0] pc, pc_add;
    logic        empty, full, uf;
    logic [7:0]  pc8, pc8_add;
    logic        empty8, full8, uf8;
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    pc_unit #(.WIDTH(32), .INC(4), .RESET_VECTOR(32'h0), .RAS_DEPTH(4)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .jump_i            (jump),
        .call_i            (call),
        .jump_target_i     (jump_target),
        .return_i          (ret),
        .pc_result_o       (pc),
        .pc_add_result_o   (pc_add),
        .ras_empty_o       (empty),
        .ras_full_o        (full),
        .ras_underflow_o   (uf)
    );

    pc_unit #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'hFC), .RAS_DEPTH(4)) dut8 (
        .clk_i             (clk),
        .reset_i           (reset),
        .stall_i           (1'b0),
        .redirect_i        (1'b0),
        .redirect_target_i (8'h00),
        .jump_i            (1'b0),
        .call_i            (1'b0),
        .jump_target_i     (8'h00),
        .return_i          (1'b0),
        .pc_result_o       (pc8),
        .pc_add_result_o   (pc8_add),
        .ras_empty_o       (empty8),
        .ras_full_o        (full8),
        .ras_underflow_o   (uf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of controls and queue the state expected after the edge.
    task automatic step(input string name, input logic r, input logic st, input logic rd,
                        input logic [31:0] rt, input logic j, input logic c,
                        input logic [31:0] jt, input logic rr, input logic [31:0] e_pc,
                        input logic e_empty, input logic e_full, input logic e_uf);
        exp_t e;
        @(negedge clk);
        reset = r; stall = st; redirect = rd; redirect_target = rt;
        jump = j; call = c; jump_target = jt; ret = rr;
        e.pc = e_pc; e.empty = e_empty; e.full = e_full; e.uf = e_uf; e.name = name;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".pc"}, pc, e.pc);
                chk({e.name, ".add"}, pc_add, e.pc + 32'd4);
                chk({e.name, ".empty"}, {31'b0, empty}, {31'b0, e.empty});
                chk({e.name, ".full"}, {31'b0, full}, {31'b0, e.full});
                chk({e.name, ".uf"}, {31'b0, uf}, {31'b0, e.uf});
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; jump = 1'b0; call = 1'b0; ret = 1'b0;
        redirect_target = '0; jump_target = '0;
        //            name        r  st rd rt        j  c  jt        rr pc         em fu uf
        step("reset",   1, 0, 0, 0,        0, 0, 0,        0, 32'h0,    1, 0, 0);
        @(posedge clk); #1;
        chk("w8.reset.pc",  {24'b0, pc8},     32'hFC);
        chk("w8.reset.add", {24'b0, pc8_add}, 32'h00);
        step("seq1",    0, 0, 0, 0,        0, 0, 0,        0, 32'h4,    1, 0, 0);
        @(posedge clk); #1;
        chk("w8.wrap.pc",   {24'b0, pc8},     32'h00);
        chk("w8.wrap.add",  {24'b0, pc8_add}, 32'h04);
        step("seq2",    0, 0, 0, 0,        0, 0, 0,        0, 32'h8,    1, 0, 0);
        step("seq3",    0, 0, 0, 0,        0, 0, 0,        0, 32'hC,    1, 0, 0);
        step("seq4",    0, 0, 0, 0,        0, 0, 0,        0, 32'h10,   1, 0, 0);
        step("stall1",  0, 1, 0, 0,        0, 0, 0,        0, 32'h10,   1, 0, 0);
        step("stall2",  0, 1, 0, 0,        0, 0, 0,        0, 32'h10,   1, 0, 0);
        step("redir_st",0, 1, 1, 32'h400,  0, 0, 0,        0, 32'h400,  1, 0, 0);
        step("stallcal",0, 1, 0, 0,        0, 1, 32'h900,  0, 32'h400,  1, 0, 0);
        step("redircal",0, 0, 1, 32'h20,   0, 1, 32'h900,  0, 32'h20,   1, 0, 0);
        step("call",    0, 0, 0, 0,        0, 1, 32'h100,  0, 32'h100,  0, 0, 0);
        step("body1",   0, 0, 0, 0,        0, 0, 0,        0, 32'h104,  0, 0, 0);
        step("body2",   0, 0, 0, 0,        0, 0, 0,        0, 32'h108,  0, 0, 0);
        step("ret",     0, 0, 0, 0,        0, 0, 0,        1, 32'h24,   1, 0, 0);
        step("to0",     0, 0, 1, 32'h0,    0, 0, 0,        0, 32'h0,    1, 0, 0);
        step("c1",      0, 0, 0, 0,        0, 1, 32'h100,  0, 32'h100,  0, 0, 0);
        step("c2",      0, 0, 0, 0,        0, 1, 32'h200,  0, 32'h200,  0, 0, 0);
        step("c3",      0, 0, 0, 0,        0, 1, 32'h300,  0, 32'h300,  0, 0, 0);
        step("c4",      0, 0, 0, 0,        0, 1, 32'h400,  0, 32'h400,  0, 1, 0);
        step("c5",      0, 0, 0, 0,        0, 1, 32'h500,  0, 32'h500,  0, 1, 0);
        step("r1",      0, 0, 0, 0,        0, 0, 0,        1, 32'h404,  0, 0, 0);
        step("r2",      0, 0, 0, 0,        0, 0, 0,        1, 32'h304,  0, 0, 0);
        step("r3",      0, 0, 0, 0,        0, 0, 0,        1, 32'h204,  0, 0, 0);
        step("r4",      0, 0, 0, 0,        0, 0, 0,        1, 32'h104,  1, 0, 0);
        step("jump",    0, 0, 0, 0,        1, 0, 32'h200,  0, 32'h200,  1, 0, 0);
        step("to30",    0, 0, 1, 32'h30,   0, 0, 0,        0, 32'h30,   1, 0, 0);
        step("uf_ret",  0, 0, 0, 0,        0, 0, 0,        1, 32'h34,   1, 0, 1);
        step("uf_seq",  0, 0, 0, 0,        0, 0, 0,        0, 32'h38,   1, 0, 1);
        step("uf_stall",0, 1, 0, 0,        0, 0, 0,        0, 32'h38,   1, 0, 1);
        step("rst2",    1, 1, 1, 32'h700,  0, 1, 32'h800,  1, 32'h0,    1, 0, 0);
        step("sc_call", 0, 0, 0, 0,        0, 1, 32'h80,   0, 32'h80,   0, 0, 0);
        step("swap",    0, 0, 0, 0,        0, 1, 32'h900,  1, 32'h4,    0, 0, 0);
        step("sw_ret",  0, 0, 0, 0,        0, 0, 0,        1, 32'h84,   1, 0, 0);
        step("fill1",   0, 0, 0, 0,        0, 1, 32'h10,   0, 32'h10,   0, 0, 0);
        step("fill2",   0, 0, 0, 0,        0, 1, 32'h20,   0, 32'h20,   0, 0, 0);
        step("fill3",   0, 0, 0, 0,        0, 1, 32'h30,   0, 32'h30,   0, 0, 0);
        step("fill4",   0, 0, 0, 0,        0, 1, 32'h40,   0, 32'h40,   0, 1, 0);
        step("rst_full",1, 0, 0, 0,        0, 0, 0,        0, 32'h0,    1, 0, 0);
        step("post_rst",0, 0, 0, 0,        0, 0, 0,        1, 32'h4,    1, 0, 1);
        step("idle",    0, 0, 0, 0,        0, 0, 0,        0, 32'h8,    1, 0, 1);
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit: PC register, PC+increment adder and prioritised next-PC selection in one clocked block.
- Adds a circular return-address stack (RAS) so call/return can be resolved at fetch.
- Sits at the head of the fetch stage. Drives the instruction-memory address and the PC+INC value carried down the pipeline.

Parameters:
- WIDTH, 32, PC/address width in bits.
- INC, 4, constant added per sequential fetch.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold PC and RAS unchanged this cycle.
- Redirect  input  1  branch/exception redirect from a later stage.
- RedirectTarget  input  WIDTH  PC to load on Redirect.
- Jump  input  1  unconditional jump (j).
- Call  input  1  call (jal): jump and push the return address.
- JumpTarget  input  WIDTH  target for Jump/Call.
- Return  input  1  return (jr $ra): pop the RAS for the next PC.
- PCResult  output  WIDTH  current PC (registered).
- PCAddResult  output  WIDTH  PCResult + INC (combinational from the register).
- RasEmpty  output  1  RAS count == 0.
- RasFull  output  1  RAS count == RAS_DEPTH.
- RasUnderflow  output  1  sticky: Return seen while the stack was empty.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- State after reset:
  - PCResult = RESET_VECTOR; PCAddResult = RESET_VECTOR + INC.
  - RAS count = 0, top pointer = 0, RasEmpty = 1, RasFull = 0, RasUnderflow = 0.
  - RAS entry contents are don't-care.
- Reset overrides every other input in the same cycle.
- Arithmetic: PCAddResult = (PCResult + INC) mod 2^WIDTH. Wrap-around is silent: all-ones - INC + 1 wraps to low addresses. Targets are used as-is, with no alignment masking.
- Next-PC priority, evaluated each rising edge, highest first:
  1. Reset -> RESET_VECTOR.
  2. Redirect -> RedirectTarget. RAS untouched; Stall is ignored.
  3. Stall -> PC and RAS hold.
  4. Return and Call together -> PC = RAS top; top entry overwritten with PCAddResult; count unchanged.
  5. Return with count > 0 -> PC = RAS top; pop (pointer decrements modulo depth, count - 1).
  6. Return with count == 0 -> PC = PCAddResult; RasUnderflow set until Reset.
  7. Call -> PC = JumpTarget; push PCAddResult.
  8. Jump -> PC = JumpTarget.
  9. Otherwise -> PC = PCAddResult.
- RAS push when full: circular overwrite of the oldest entry. Pointer advances modulo RAS_DEPTH; count saturates at RAS_DEPTH.
- Latency: a next-PC decision is visible on PCResult one cycle after the edge; a pop reads the pre-edge top.
- Control inputs are sampled only at the edge. There is no handshake beyond Stall.
- Reset mid-sequence, e.g. during a stall or with the RAS full, discards all state. No pending operation survives.

Decomposition:
- Shared package: the next-PC select encoding (RESET, REDIRECT, HOLD, RAS_SWAP, RAS_POP, SEQ, CALL, JUMP), plus default WIDTH/INC constants shared with the instruction-memory and branch-resolution blocks.
- One natural sub-module: return_stack, a circular LIFO with push/pop/swap, count, full and empty. pc_unit keeps the PC register and the priority mux.

Test Plan:
- Reset then 3 free-running cycles, RESET_VECTOR = 0 -> PCResult 0, 4, 8, 12; PCAddResult always PCResult + 4; RasEmpty = 1.
- PC = 0x10, Stall high 2 cycles, then Redirect = 1 with Stall = 1 and target 0x400 -> PC holds 0x10 for both stall cycles, then loads 0x400.
- Call at PC = 0x20 with JumpTarget 0x100, run 2 cycles, then Return:
  - PC sequence 0x100, 0x104, 0x108, then 0x24.
  - RasEmpty goes 0 after the call and back to 1 after the return.
- Five Calls with RAS_DEPTH = 4, from PC 0x0/0x100/0x200/0x300/0x400, each with a fresh target, then four Returns:
  - RasFull after the 4th call.
  - Returns yield 0x404, 0x304, 0x204, 0x104; 0x4 has been overwritten.
- Return on an empty RAS at PC = 0x30 -> PC = 0x34, RasUnderflow = 1 and stays 1 until Reset.
- WIDTH = 8, INC = 4, PC = 0xFC, no control inputs -> PCAddResult = 0x00, next PC = 0x00.
